// File: rtl/core_pkg.sv
`default_nettype none
// ============================================================================
// Module      : core_pkg
// Description : Shared widths, reset address and fetch FSM state encoding for
//               the pipelined ARM core front end.
// Revision    : 1.0 - initial release
// ============================================================================
package core_pkg;

    localparam int          C_ADDR_W   = 32;
    localparam int          C_DATA_W   = 32;
    localparam logic [31:0] C_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        DISCARD = 2'd2
    } fetch_state_t;

    typedef logic [C_DATA_W-1:0] inst_word_t;

endpackage : core_pkg
`default_nettype wire

// File: rtl/if_id_reg.sv
`default_nettype none
// ============================================================================
// Module      : if_id_reg
// Description : IF/ID pipeline register with load, hold and flush; also
//               presents the ARM PC read value (pc + 8) of the held word.
// Revision    : 1.0 - initial release
// ============================================================================
module if_id_reg
    import core_pkg::*;
#(
    parameter int ADDR_W = C_ADDR_W,
    parameter int DATA_W = C_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_load,
    input  logic              i_flush,
    input  logic [DATA_W-1:0] i_inst,
    input  logic [ADDR_W-1:0] i_pc,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_inst,
    output logic [ADDR_W-1:0] o_pc,
    output logic [ADDR_W-1:0] o_pc_plus8
);

    localparam logic [ADDR_W-1:0] C_PC_READ_OFFSET = ADDR_W'(8);

    logic              r_valid;
    logic [DATA_W-1:0] r_inst;
    logic [ADDR_W-1:0] r_pc;

    // Flush only clears the valid flag; the stale word is never consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_inst  <= '0;
            r_pc    <= '0;
        end else if (i_flush) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_inst  <= i_inst;
            r_pc    <= i_pc;
        end
    end

    assign o_valid    = r_valid;
    assign o_inst     = r_inst;
    assign o_pc       = r_pc;
    assign o_pc_plus8 = r_pc + C_PC_READ_OFFSET;

endmodule : if_id_reg
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage
// Description : Instruction fetch stage: owns the PC, issues reads to the
//               instruction memory and handles stall and branch redirects,
//               including redirects while a read is still unacknowledged.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage
    import core_pkg::*;
#(
    parameter int                ADDR_W   = C_ADDR_W,
    parameter int                DATA_W   = C_DATA_W,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(C_RESET_PC)
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] inst_address,
    output logic              inst_read,
    input  logic [DATA_W-1:0] inst_out,
    input  logic              inst_ready,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    output logic              if_valid,
    output logic [DATA_W-1:0] if_inst,
    output logic [ADDR_W-1:0] if_pc,
    output logic [ADDR_W-1:0] if_pc_plus8
);

    localparam logic [ADDR_W-1:0] C_PC_STEP    = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] C_ALIGN_MASK = ~ADDR_W'(3);

    fetch_state_t      r_state;
    fetch_state_t      w_state_next;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] w_pc_next;
    logic [ADDR_W-1:0] r_redirect_pc;
    logic [ADDR_W-1:0] w_redirect_next;
    logic [ADDR_W-1:0] w_target;
    logic              w_read;
    logic              w_load;
    logic              w_flush;
    logic              w_hold;

    assign w_target = branch_target & C_ALIGN_MASK;
    assign w_hold   = if_valid & stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc          <= RESET_PC;
            r_redirect_pc <= RESET_PC;
        end else begin
            r_pc          <= w_pc_next;
            r_redirect_pc <= w_redirect_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_pc_next       = r_pc;
        w_redirect_next = r_redirect_pc;
        w_read          = 1'b0;
        w_load          = 1'b0;
        w_flush         = 1'b0;

        case (r_state)
            IDLE: begin
                w_state_next = FETCH;
                if (branch_taken) begin
                    w_pc_next = w_target;
                end
            end

            FETCH: begin
                w_read = ~w_hold;
                if (branch_taken) begin
                    w_flush = 1'b1;
                    // An unacknowledged read must finish at its own address
                    // before the redirect can take effect.
                    if (w_read && !inst_ready) begin
                        w_redirect_next = w_target;
                        w_state_next    = DISCARD;
                    end else begin
                        w_pc_next = w_target;
                    end
                end else if (!w_hold) begin
                    if (inst_ready) begin
                        w_load    = 1'b1;
                        w_pc_next = r_pc + C_PC_STEP;
                    end else begin
                        w_flush = 1'b1;
                    end
                end
            end

            DISCARD: begin
                w_read  = 1'b1;
                w_flush = 1'b1;
                if (branch_taken) begin
                    w_redirect_next = w_target;
                end
                if (inst_ready) begin
                    w_pc_next    = branch_taken ? w_target : r_redirect_pc;
                    w_state_next = FETCH;
                end
            end

            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    assign inst_address = r_pc;
    assign inst_read    = w_read;

    if_id_reg #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_if_id_reg (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_load),
        .i_flush    (w_flush),
        .i_inst     (inst_out),
        .i_pc       (r_pc),
        .o_valid    (if_valid),
        .o_inst     (if_inst),
        .o_pc       (if_pc),
        .o_pc_plus8 (if_pc_plus8)
    );

endmodule : fetch_stage
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_stage
// Description : Self-checking bench for fetch_stage: directed scenarios plus a
//               randomized run against a behavioural reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

    logic        clk;
    logic        rst_n;
    logic [31:0] inst_address;
    logic        inst_read;
    logic [31:0] inst_out;
    logic        inst_ready;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        if_valid;
    logic [31:0] if_inst;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus8;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    bit          m_run;
    bit          m_disc;
    bit          m_valid;
    logic [31:0] m_pc;
    logic [31:0] m_redir;
    logic [31:0] m_inst;
    logic [31:0] m_ifpc;

    fetch_stage #(
        .ADDR_W   (32),
        .DATA_W   (32),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .inst_address  (inst_address),
        .inst_read     (inst_read),
        .inst_out      (inst_out),
        .inst_ready    (inst_ready),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .if_valid      (if_valid),
        .if_inst       (if_inst),
        .if_pc         (if_pc),
        .if_pc_plus8   (if_pc_plus8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'hE1A0_0000 ^ {a[15:0], a[31:16]};
    endfunction

    assign inst_out = mem_word(inst_address);

    task automatic step(input logic st, input logic br, input logic rdy, input logic [31:0] tgt);
        @(negedge clk);
        stall         = st;
        branch_taken  = br;
        inst_ready    = rdy;
        branch_target = tgt;
        #1;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        step(1'b0, 1'b0, 1'b1, 32'h0);
        step(1'b0, 1'b0, 1'b1, 32'h0);
        rst_n = 1'b1;
    endtask

    // Advances the model across one rising edge with the given inputs.
    task automatic model_step(input logic st, input logic br, input logic rdy, input logic [31:0] tgt);
        logic [31:0] t;
        logic        rd;
        t = tgt & 32'hFFFF_FFFC;
        if (!m_run) begin
            m_run = 1'b1;
            if (br) m_pc = t;
        end else if (m_disc) begin
            if (br) m_redir = t;
            if (rdy) begin
                m_pc   = m_redir;
                m_disc = 1'b0;
            end
        end else begin
            rd = !(m_valid && st);
            if (br) begin
                m_valid = 1'b0;
                if (rd && !rdy) begin
                    m_redir = t;
                    m_disc  = 1'b1;
                end else begin
                    m_pc = t;
                end
            end else if (rd) begin
                if (rdy) begin
                    m_valid = 1'b1;
                    m_inst  = mem_word(m_pc);
                    m_ifpc  = m_pc;
                    m_pc    = m_pc + 32'd4;
                end else begin
                    m_valid = 1'b0;
                end
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        step(1'b0, 1'b0, 1'b1, 32'h0);
        n_checks++;
        if ({inst_address, inst_read, if_valid, if_inst, if_pc, if_pc_plus8} !==
            {32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h8}) begin
            n_errors++;
            $display("FAIL reset_values: got addr=%h rd=%b v=%b inst=%h pc=%h pc8=%h expected 0 0 0 0 0 8",
                     inst_address, inst_read, if_valid, if_inst, if_pc, if_pc_plus8);
        end
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (inst_read !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_release_read: got %b expected 0", inst_read);
        end
        step(1'b0, 1'b0, 1'b1, 32'h0);
        n_checks++;
        if ({inst_read, inst_address} !== {1'b1, 32'h0}) begin
            n_errors++;
            $display("FAIL first_read: got rd=%b addr=%h expected rd=1 addr=0", inst_read, inst_address);
        end
    endtask

    task automatic test_free_run;
        logic [31:0] ep;
        do_reset();
        step(1'b0, 1'b0, 1'b1, 32'h0);
        n_checks++;
        if ({inst_read, inst_address, if_valid} !== {1'b1, 32'h0, 1'b0}) begin
            n_errors++;
            $display("FAIL free_run_start: got rd=%b addr=%h v=%b expected 1 0 0", inst_read, inst_address, if_valid);
        end
        for (int k = 1; k <= 4; k++) begin
            step(1'b0, 1'b0, 1'b1, 32'h0);
            ep = 32'(4 * (k - 1));
            n_checks++;
            if ({inst_address, if_valid, if_pc, if_inst, if_pc_plus8} !==
                {32'(4 * k), 1'b1, ep, mem_word(ep), ep + 32'd8}) begin
                n_errors++;
                $display("FAIL free_run_%0d: got addr=%h v=%b pc=%h inst=%h pc8=%h expected addr=%h pc=%h inst=%h",
                         k, inst_address, if_valid, if_pc, if_inst, if_pc_plus8, 32'(4 * k), ep, mem_word(ep));
            end
        end
    endtask

    task automatic test_stall;
        do_reset();
        step(1'b0, 1'b0, 1'b1, 32'h0);
        step(1'b0, 1'b0, 1'b1, 32'h0);
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 1'b0, 1'b1, 32'h0);
            n_checks++;
            if ({inst_read, inst_address, if_valid, if_pc, if_inst} !==
                {1'b0, 32'h8, 1'b1, 32'h4, mem_word(32'h4)}) begin
                n_errors++;
                $display("FAIL stall_hold_%0d: got rd=%b addr=%h v=%b pc=%h inst=%h expected rd=0 addr=8 pc=4",
                         k, inst_read, inst_address, if_valid, if_pc, if_inst);
            end
        end
        step(1'b0, 1'b0, 1'b1, 32'h0);
        n_checks++;
        if ({inst_read, inst_address, if_pc} !== {1'b1, 32'h8, 32'h4}) begin
            n_errors++;
            $display("FAIL stall_release_read: got rd=%b addr=%h pc=%h expected 1 8 4", inst_read, inst_address, if_pc);
        end
        step(1'b0, 1'b0, 1'b1, 32'h0);
        n_checks++;
        if ({if_valid, if_pc, if_inst} !== {1'b1, 32'h8, mem_word(32'h8)}) begin
            n_errors++;
            $display("FAIL stall_release_load: got v=%b pc=%h inst=%h expected v=1 pc=8", if_valid, if_pc, if_inst);
        end
    endtask

    task automatic test_branch;
        do_reset();
        step(1'b0, 1'b0, 1'b1, 32'h0);
        step(1'b0, 1'b0, 1'b1, 32'h0);
        step(1'b0, 1'b0, 1'b1, 32'h0);
        step(1'b0, 1'b1, 1'b1, 32'h41);
        n_checks++;
        if ({inst_address, if_pc} !== {32'hC, 32'h8}) begin
            n_errors++;
            $display("FAIL branch_issue: got addr=%h pc=%h expected C 8", inst_address, if_pc);
        end
        step(1'b0, 1'b0, 1'b1, 32'h0);
        n_checks++;
        if ({if_valid, inst_address, inst_read} !== {1'b0, 32'h40, 1'b1}) begin
            n_errors++;
            $display("FAIL branch_bubble: got v=%b addr=%h rd=%b expected 0 40 1", if_valid, inst_address, inst_read);
        end
        step(1'b0, 1'b0, 1'b1, 32'h0);
        n_checks++;
        if ({if_valid, if_pc, if_inst} !== {1'b1, 32'h40, mem_word(32'h40)}) begin
            n_errors++;
            $display("FAIL branch_target: got v=%b pc=%h inst=%h expected v=1 pc=40", if_valid, if_pc, if_inst);
        end
    endtask

    task automatic test_branch_during_wait;
        do_reset();
        step(1'b0, 1'b0, 1'b1, 32'h0);
        step(1'b0, 1'b0, 1'b1, 32'h0);
        step(1'b0, 1'b1, 1'b0, 32'h100);
        n_checks++;
        if ({inst_address, inst_read} !== {32'h8, 1'b1}) begin
            n_errors++;
            $display("FAIL wait_issue: got addr=%h rd=%b expected 8 1", inst_address, inst_read);
        end
        step(1'b0, 1'b0, 1'b0, 32'h0);
        n_checks++;
        if ({inst_address, inst_read, if_valid} !== {32'h8, 1'b1, 1'b0}) begin
            n_errors++;
            $display("FAIL wait_discard_1: got addr=%h rd=%b v=%b expected 8 1 0", inst_address, inst_read, if_valid);
        end
        step(1'b0, 1'b0, 1'b1, 32'h0);
        n_checks++;
        if ({inst_address, inst_read, if_valid} !== {32'h8, 1'b1, 1'b0}) begin
            n_errors++;
            $display("FAIL wait_discard_2: got addr=%h rd=%b v=%b expected 8 1 0", inst_address, inst_read, if_valid);
        end
        step(1'b0, 1'b0, 1'b1, 32'h0);
        n_checks++;
        if ({inst_address, inst_read, if_valid} !== {32'h100, 1'b1, 1'b0}) begin
            n_errors++;
            $display("FAIL wait_redirect: got addr=%h rd=%b v=%b expected 100 1 0", inst_address, inst_read, if_valid);
        end
        step(1'b0, 1'b0, 1'b1, 32'h0);
        n_checks++;
        if ({if_valid, if_pc, if_inst} !== {1'b1, 32'h100, mem_word(32'h100)}) begin
            n_errors++;
            $display("FAIL wait_target: got v=%b pc=%h inst=%h expected v=1 pc=100", if_valid, if_pc, if_inst);
        end
    endtask

    task automatic test_branch_and_stall;
        do_reset();
        step(1'b0, 1'b0, 1'b1, 32'h0);
        step(1'b1, 1'b1, 1'b1, 32'h200);
        n_checks++;
        if (inst_read !== 1'b0) begin
            n_errors++;
            $display("FAIL bstall_read: got %b expected 0", inst_read);
        end
        step(1'b0, 1'b0, 1'b1, 32'h0);
        n_checks++;
        if ({if_valid, inst_address, inst_read} !== {1'b0, 32'h200, 1'b1}) begin
            n_errors++;
            $display("FAIL bstall_bubble: got v=%b addr=%h rd=%b expected 0 200 1", if_valid, inst_address, inst_read);
        end
        step(1'b0, 1'b0, 1'b1, 32'h0);
        n_checks++;
        if ({if_valid, if_pc} !== {1'b1, 32'h200}) begin
            n_errors++;
            $display("FAIL bstall_target: got v=%b pc=%h expected 1 200", if_valid, if_pc);
        end
    endtask

    task automatic test_async_reset;
        do_reset();
        step(1'b0, 1'b0, 1'b1, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({inst_address, inst_read, if_valid, if_inst, if_pc, if_pc_plus8} !==
            {32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h8}) begin
            n_errors++;
            $display("FAIL async_reset: got addr=%h rd=%b v=%b inst=%h pc=%h pc8=%h expected 0 0 0 0 0 8",
                     inst_address, inst_read, if_valid, if_inst, if_pc, if_pc_plus8);
        end
        step(1'b0, 1'b0, 1'b1, 32'h0);
        rst_n = 1'b1;
        step(1'b0, 1'b0, 1'b1, 32'h0);
        n_checks++;
        if ({inst_address, inst_read, if_valid} !== {32'h0, 1'b1, 1'b0}) begin
            n_errors++;
            $display("FAIL async_restart: got addr=%h rd=%b v=%b expected 0 1 0", inst_address, inst_read, if_valid);
        end
        step(1'b0, 1'b0, 1'b1, 32'h0);
        n_checks++;
        if ({if_valid, if_pc} !== {1'b1, 32'h0}) begin
            n_errors++;
            $display("FAIL async_first_inst: got v=%b pc=%h expected 1 0", if_valid, if_pc);
        end
    endtask

    task automatic test_pc_wrap;
        do_reset();
        step(1'b0, 1'b0, 1'b1, 32'h0);
        step(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF);
        step(1'b0, 1'b0, 1'b1, 32'h0);
        n_checks++;
        if ({inst_address, if_valid} !== {32'hFFFF_FFFC, 1'b0}) begin
            n_errors++;
            $display("FAIL wrap_target: got addr=%h v=%b expected FFFFFFFC 0", inst_address, if_valid);
        end
        step(1'b0, 1'b0, 1'b1, 32'h0);
        n_checks++;
        if ({if_valid, if_pc, if_pc_plus8, inst_address} !== {1'b1, 32'hFFFF_FFFC, 32'h4, 32'h0}) begin
            n_errors++;
            $display("FAIL wrap_top: got v=%b pc=%h pc8=%h addr=%h expected 1 FFFFFFFC 4 0",
                     if_valid, if_pc, if_pc_plus8, inst_address);
        end
        step(1'b0, 1'b0, 1'b1, 32'h0);
        n_checks++;
        if ({if_valid, if_pc, if_pc_plus8, inst_address} !== {1'b1, 32'h0, 32'h8, 32'h4}) begin
            n_errors++;
            $display("FAIL wrap_zero: got v=%b pc=%h pc8=%h addr=%h expected 1 0 8 4",
                     if_valid, if_pc, if_pc_plus8, inst_address);
        end
    endtask

    task automatic test_random;
        logic        st, br, rdy, exp_rd;
        logic [31:0] tgt;
        do_reset();
        m_run   = 1'b0;
        m_disc  = 1'b0;
        m_valid = 1'b0;
        m_pc    = 32'h0;
        m_redir = 32'h0;
        m_inst  = 32'h0;
        m_ifpc  = 32'h0;
        model_step(1'b0, 1'b0, 1'b1, 32'h0);
        for (int n = 0; n < 500; n++) begin
            st  = ($urandom_range(0, 9) < 3);
            br  = ($urandom_range(0, 9) == 0);
            rdy = ($urandom_range(0, 9) < 7);
            tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 15)))
                                              : 32'($urandom_range(0, 255));
            step(st, br, rdy, tgt);
            exp_rd = !m_run ? 1'b0 : (m_disc ? 1'b1 : !(m_valid && st));
            n_checks++;
            if ({inst_read, inst_address, if_valid} !== {exp_rd, m_pc, m_valid}) begin
                n_errors++;
                $display("FAIL rand_ctrl_%0d: got rd=%b addr=%h v=%b expected rd=%b addr=%h v=%b",
                         n, inst_read, inst_address, if_valid, exp_rd, m_pc, m_valid);
            end
            if (m_valid) begin
                n_checks++;
                if ({if_inst, if_pc, if_pc_plus8} !== {m_inst, m_ifpc, m_ifpc + 32'd8}) begin
                    n_errors++;
                    $display("FAIL rand_data_%0d: got inst=%h pc=%h pc8=%h expected inst=%h pc=%h pc8=%h",
                             n, if_inst, if_pc, if_pc_plus8, m_inst, m_ifpc, m_ifpc + 32'd8);
                end
            end
            model_step(st, br, rdy, tgt);
        end
    endtask

    initial begin
        rst_n         = 1'b0;
        stall         = 1'b0;
        branch_taken  = 1'b0;
        inst_ready    = 1'b1;
        branch_target = 32'h0;
        test_reset();
        test_free_run();
        test_stall();
        test_branch();
        test_branch_during_wait();
        test_branch_and_stall();
        test_async_reset();
        test_pc_wrap();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_fetch_stage
`default_nettype wire

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage of the pipelined ARM core, directly upstream of `instruction_memory`. Owns the program counter, drives `inst_address`/`inst_read`, accepts the returned word, and presents it with its PC to decode through the IF/ID pipeline register. Handles decode back-pressure (stall) and branch redirects, including redirects that arrive while a memory read is still outstanding.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, instruction width
- `RESET_PC`, 32'h0000_0000, first fetch address after reset (word aligned)

- `clk` in 1: single clock, rising edge
- `rst_n` in 1: reset, asynchronous, active-low
- `inst_address` out ADDR_W: fetch address to instruction memory
- `inst_read` out 1: read request
- `inst_out` in DATA_W: instruction word from memory
- `inst_ready` in 1: `inst_out` valid for current request (tie high for the combinational memory)
- `stall` in 1: decode cannot accept a new instruction
- `branch_taken` in 1: redirect request, single-cycle pulse
- `branch_target` in ADDR_W: redirect address; bits [1:0] ignored (forced 0)
- `if_valid` out 1: IF/ID register holds a valid instruction
- `if_inst` out DATA_W: instruction
- `if_pc` out ADDR_W: address of `if_inst`
- `if_pc_plus8` out ADDR_W: `if_pc + 8` (ARM PC read value)

## Operation
- State machine: IDLE, FETCH, DISCARD.
- IDLE: entered on reset; `inst_read`=0; next edge -> FETCH.
- FETCH: `inst_read`=1 unless (`if_valid` & `stall`); `inst_address`=`pc`. Accept = `inst_read` & `inst_ready`. On accept without branch: IF/ID loads {`inst_out`, `pc`}, `if_valid`<=1, `pc`<=`pc`+4.
- Output hold: when `if_valid` & `stall` & no branch, IF/ID and `pc` unchanged, `inst_read`=0.
- No accept and not stalled: `if_valid`<=0 (bubble).
- Branch in FETCH with no outstanding request, or coinciding with accept: response (if any) dropped, `pc`<={target[31:2],2'b00}, `if_valid`<=0, stay FETCH.
- Branch in FETCH with request outstanding (`inst_read`=1, `inst_ready`=0): latch target in `redirect_pc`, `if_valid`<=0, -> DISCARD.
- DISCARD: `inst_read`=1, `inst_address` held at old `pc` (address must not change while a request is unacknowledged). On `inst_ready`: data dropped, `pc`<=`redirect_pc`, -> FETCH. A further branch in DISCARD overwrites `redirect_pc`.
- Priority: reset > branch > stall > accept.
- PC arithmetic modulo 2^ADDR_W: 32'hFFFF_FFFC + 4 = 0; `if_pc_plus8` wraps likewise.

## Timing
- Reset values: `inst_address`=RESET_PC, `inst_read`=0, `if_valid`=0, `if_inst`=0, `if_pc`=0, `if_pc_plus8`=8; state IDLE, `pc`=RESET_PC.
- Reset is asynchronous: asserting `rst_n` mid-request forces all reset values immediately; outstanding response ignored.
- First `inst_read`=1 one cycle after reset release.
- Latency: address issue to `if_valid` = 1 cycle when `inst_ready` is high in the issue cycle; `inst_ready` wait cycles add one each.
- Throughput: 1 instruction/cycle with `inst_ready` tied high and no stall.
- Stall release: `inst_read` reasserts combinationally in the same cycle; next instruction loads at that edge — no lost cycle.
- Branch: bubble in `if_valid` the cycle after `branch_taken`; target instruction in IF/ID 2 cycles after pulse (zero-wait memory).

## Structure
- Shared package `core_pkg`: `ADDR_W`/`DATA_W` defaults, `RESET_PC`, `fetch_state_t` enum {IDLE, FETCH, DISCARD}, instruction word typedef.
- One sub-module: `if_id_reg` (IF/ID pipeline register with load, hold, flush, async active-low reset). PC/FSM logic in `fetch_stage`.

## Test plan
- Reset then free run, zero-wait memory preloaded 0x00..0x10: `inst_address` 0,4,8,… one per cycle; `if_pc`=0 with `if_inst`=mem[0] two edges after release; `if_pc_plus8`=8.
- `stall` high 3 cycles while `if_pc`=4: `if_inst`/`if_pc` held, `inst_read`=0; release -> `if_pc`=8 on next edge.
- `branch_taken` with target 0x41 at `pc`=0x0C: next `if_valid`=0, then `if_pc`=0x40; 0x0C never appears in IF/ID.
- `inst_ready` low 2 cycles for address 0x8, branch to 0x100 in first wait cycle: `inst_address` stays 0x8 until ready, data dropped, next request 0x100.
- Branch and stall same cycle: `if_valid`=0 next cycle, fetch resumes at target.
- `rst_n` asserted mid-wait: outputs at reset values immediately, first request after release at RESET_PC; PC wrap from 0xFFFFFFFC -> 0.
